// File: rtl/toll_pkg.sv
// Shared lane state encoding, 7-segment table and hi-pass tag decode helpers.
package toll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_TAG = 2'd1,
        ST_PASS     = 2'd2,
        ST_VIOL     = 2'd3
    } lane_state_e;

    localparam int unsigned SEG_W      = 7;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 10;

    // Index 0 is the rightmost entry; bit0 of each entry is segment a.
    localparam logic [NUM_DIGITS-1:0][SEG_W-1:0] SEG_TABLE = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Nonzero tag with MSB set: valid tag with sufficient balance.
    function automatic logic is_valid(input logic nonzero, input logic msb);
        return nonzero && msb;
    endfunction

    // Nonzero tag with MSB clear: tag present but balance too low.
    function automatic logic is_low(input logic nonzero, input logic msb);
        return nonzero && !msb;
    endfunction

    // Digit to segment pattern; out-of-range digits blank the display.
    function automatic logic [SEG_W-1:0] seg_of(input logic [DIGIT_W-1:0] digit);
        return (digit < DIGIT_W'(NUM_DIGITS)) ? SEG_TABLE[digit] : SEG_W'(0);
    endfunction

endpackage

// File: rtl/toll_lane_fsm.sv
// One toll lane: car edge detect, tag wait timer, gate control and event strobes.
module toll_lane_fsm
    import toll_pkg::*;
#(
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             car,
    input  logic [TAG_W-1:0] tag,
    output logic             gate,
    output logic             pass_ev_c,
    output logic             viol_ev_c
);

    localparam int unsigned     TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    lane_state_e      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             car_q;
    logic             tag_nz;
    logic             tag_msb;

    assign tag_nz  = |tag;
    assign tag_msb = tag[TAG_W-1];

    // State, timer, edge detector and gate registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            car_q   <= 1'b0;
            gate    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            car_q   <= car;
            gate    <= (state_d == ST_PASS);
        end
    end

    // Next-state, timer update and 1-cycle event strobes.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pass_ev_c = 1'b0;
        viol_ev_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (car && !car_q) begin
                    state_d = ST_WAIT_TAG;
                    timer_d = TMR_LOAD;
                end
            end
            ST_WAIT_TAG: begin
                if (!car) begin
                    state_d   = ST_VIOL;
                    viol_ev_c = 1'b1;
                end else if (is_valid(tag_nz, tag_msb)) begin
                    state_d   = ST_PASS;
                    pass_ev_c = 1'b1;
                end else if (is_low(tag_nz, tag_msb)) begin
                    state_d   = ST_VIOL;
                    viol_ev_c = 1'b1;
                end else if (timer_q == '0) begin
                    state_d   = ST_VIOL;
                    viol_ev_c = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_PASS: begin
                if (!car) state_d = ST_IDLE;
            end
            ST_VIOL: begin
                if (!car) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/hipass_toll_ctrl.sv
// Multi-lane hi-pass toll controller: per-lane FSMs plus shared pass digit,
// saturating violation counter and retriggerable buzzer.
module hipass_toll_ctrl
    import toll_pkg::*;
#(
    parameter int unsigned LANES     = 2,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned SOUND_CYC = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LANES-1:0]         car,
    input  logic [LANES*TAG_W-1:0]   hipass_out,
    output logic [LANES-1:0]         gate,
    output logic [6:0]               out,
    output logic                     sound,
    output logic [CNT_W-1:0]         viol_cnt
);

    localparam int unsigned PC_W   = $clog2(LANES + 1);
    localparam int unsigned VSUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam int unsigned SND_W  = $clog2(SOUND_CYC + 1);
    localparam int unsigned DSUM_W = DIGIT_W + 1;
    localparam logic [VSUM_W-1:0] CNT_MAX = VSUM_W'({CNT_W{1'b1}});

    logic [LANES-1:0]   pass_ev;
    logic [LANES-1:0]   viol_ev;
    logic [PC_W-1:0]    pass_pc;
    logic [PC_W-1:0]    viol_pc;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic [DSUM_W-1:0]  digit_sum;
    logic [VSUM_W-1:0]  viol_sum;
    logic [CNT_W-1:0]   viol_d;
    logic [SND_W-1:0]   snd_q, snd_d;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        toll_lane_fsm #(
            .TAG_W   (TAG_W),
            .TIMEOUT (TIMEOUT)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .car       (car[i]),
            .tag       (hipass_out[i*TAG_W +: TAG_W]),
            .gate      (gate[i]),
            .pass_ev_c (pass_ev[i]),
            .viol_ev_c (viol_ev[i])
        );
    end

    // Count this cycle's pass and violation strobes across all lanes.
    always_comb begin
        pass_pc = '0;
        viol_pc = '0;
        for (int i = 0; i < LANES; i++) begin
            pass_pc = pass_pc + PC_W'(pass_ev[i]);
            viol_pc = viol_pc + PC_W'(viol_ev[i]);
        end
    end

    // Next digit (mod 10), saturating violation count and buzzer counter.
    always_comb begin
        digit_sum = DSUM_W'(digit_q) + DSUM_W'(pass_pc);
        digit_d   = (digit_sum >= DSUM_W'(NUM_DIGITS)) ?
                    DIGIT_W'(digit_sum - DSUM_W'(NUM_DIGITS)) : DIGIT_W'(digit_sum);
        viol_sum  = VSUM_W'(viol_cnt) + VSUM_W'(viol_pc);
        viol_d    = (viol_sum > CNT_MAX) ? {CNT_W{1'b1}} : CNT_W'(viol_sum);
        snd_d     = snd_q;
        if (|viol_ev) begin
            snd_d = SND_W'(SOUND_CYC);
        end else if (snd_q != '0) begin
            snd_d = snd_q - SND_W'(1);
        end
    end

    // Shared counters and registered display/buzzer outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_q  <= '0;
            out      <= SEG_TABLE[0];
            viol_cnt <= '0;
            snd_q    <= '0;
            sound    <= 1'b0;
        end else begin
            digit_q  <= digit_d;
            out      <= seg_of(digit_d);
            viol_cnt <= viol_d;
            snd_q    <= snd_d;
            sound    <= (snd_d != '0);
        end
    end

endmodule

// File: tb/tb_hipass_toll_ctrl.sv
// Directed bench for hipass_toll_ctrl: vector table plus multi-cycle sequences.
module tb_hipass_toll_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] car;
    logic [7:0] hp;
    logic [1:0] gate;
    logic [6:0] out;
    logic       sound;
    logic [7:0] viol_cnt;

    logic [1:0] car2;
    logic [7:0] hp2;
    logic [1:0] gate2;
    logic [6:0] out2;
    logic       sound2;
    logic [1:0] viol_cnt2;

    int checks;
    int failures;

    logic [6:0] seg_ref [10];

    typedef struct {
        logic [1:0] car;
        logic [7:0] hp;
        logic [1:0] gate;
        logic [6:0] seg;
        logic       snd;
        logic [7:0] viol;
    } vec_t;

    vec_t tbl [18];

    hipass_toll_ctrl #(
        .LANES(2), .TAG_W(4), .CNT_W(8), .TIMEOUT(16), .SOUND_CYC(4)
    ) dut (
        .clk(clk), .rst(rst), .car(car), .hipass_out(hp),
        .gate(gate), .out(out), .sound(sound), .viol_cnt(viol_cnt)
    );

    hipass_toll_ctrl #(
        .LANES(2), .TAG_W(4), .CNT_W(2), .TIMEOUT(16), .SOUND_CYC(4)
    ) dut2 (
        .clk(clk), .rst(rst), .car(car2), .hipass_out(hp2),
        .gate(gate2), .out(out2), .sound(sound2), .viol_cnt(viol_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Lane0 passes through a full car-rise / tag / car-fall cycle on dut.
    task automatic lane0_pass();
        car = 2'b01; hp = 8'h00; tick();
        hp = 8'h0E; tick();
        car = 2'b00; hp = 8'h00; tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        seg_ref  = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

        // car, hipass, gate, seg, sound, viol -- starting with digit=1, viol=0
        tbl[0]  = '{2'b01, 8'h00, 2'b00, 7'h06, 1'b0, 8'd0};
        tbl[1]  = '{2'b01, 8'h00, 2'b00, 7'h06, 1'b0, 8'd0};
        tbl[2]  = '{2'b01, 8'h0E, 2'b01, 7'h5B, 1'b0, 8'd0};
        tbl[3]  = '{2'b01, 8'h0E, 2'b01, 7'h5B, 1'b0, 8'd0};
        tbl[4]  = '{2'b00, 8'h00, 2'b00, 7'h5B, 1'b0, 8'd0};
        tbl[5]  = '{2'b10, 8'h00, 2'b00, 7'h5B, 1'b0, 8'd0};
        tbl[6]  = '{2'b10, 8'h40, 2'b00, 7'h5B, 1'b1, 8'd1};
        tbl[7]  = '{2'b10, 8'h40, 2'b00, 7'h5B, 1'b1, 8'd1};
        tbl[8]  = '{2'b10, 8'h00, 2'b00, 7'h5B, 1'b1, 8'd1};
        tbl[9]  = '{2'b00, 8'h00, 2'b00, 7'h5B, 1'b1, 8'd1};
        tbl[10] = '{2'b00, 8'h00, 2'b00, 7'h5B, 1'b0, 8'd1};
        tbl[11] = '{2'b00, 8'hFF, 2'b00, 7'h5B, 1'b0, 8'd1};
        tbl[12] = '{2'b01, 8'h00, 2'b00, 7'h5B, 1'b0, 8'd1};
        tbl[13] = '{2'b00, 8'h00, 2'b00, 7'h5B, 1'b1, 8'd2};
        tbl[14] = '{2'b00, 8'h00, 2'b00, 7'h5B, 1'b1, 8'd2};
        tbl[15] = '{2'b00, 8'h00, 2'b00, 7'h5B, 1'b1, 8'd2};
        tbl[16] = '{2'b00, 8'h00, 2'b00, 7'h5B, 1'b1, 8'd2};
        tbl[17] = '{2'b00, 8'h00, 2'b00, 7'h5B, 1'b0, 8'd2};

        // Reset with cars present and tags asserted
        rst = 1'b0; car = 2'b11; hp = 8'hEE; car2 = 2'b00; hp2 = 8'h00;
        tick(); tick();
        chk("rst_gate", 32'(gate), 32'h0);
        chk("rst_sound", 32'(sound), 32'h0);
        chk("rst_viol", 32'(viol_cnt), 32'h0);
        chk("rst_out", 32'(out), 32'h3F);

        // Car held through reset release counts as an arrival on the first edge
        car = 2'b01; hp = 8'h00; rst = 1'b1;
        tick();
        chk("arr_gate_wait", 32'(gate), 32'h0);
        hp = 8'h0E;
        tick();
        chk("arr_gate_open", 32'(gate), 32'h1);
        chk("arr_out", 32'(out), 32'h06);
        car = 2'b00; hp = 8'h00;
        tick();
        chk("arr_gate_close", 32'(gate), 32'h0);

        // Table: lane0 pass, lane1 low balance, ignored tag, lane0 drive-through
        for (int i = 0; i < 18; i++) begin
            car = tbl[i].car; hp = tbl[i].hp;
            tick();
            chk($sformatf("vec%0d_gate", i), 32'(gate), 32'(tbl[i].gate));
            chk($sformatf("vec%0d_out", i), 32'(out), 32'(tbl[i].seg));
            chk($sformatf("vec%0d_sound", i), 32'(sound), 32'(tbl[i].snd));
            chk($sformatf("vec%0d_viol", i), 32'(viol_cnt), 32'(tbl[i].viol));
        end

        // Timeout: VIOL exactly TIMEOUT edges after the car rise
        car = 2'b01; hp = 8'h00;
        tick();
        for (int k = 1; k < 16; k++) tick();
        chk("tmo_before_viol", 32'(viol_cnt), 32'd2);
        chk("tmo_before_sound", 32'(sound), 32'h0);
        tick();
        chk("tmo_viol", 32'(viol_cnt), 32'd3);
        chk("tmo_sound", 32'(sound), 32'h1);

        // Re-arrival inside the sound window extends the tone
        car = 2'b00; tick();
        chk("ext_e1_sound", 32'(sound), 32'h1);
        car = 2'b01; tick();
        chk("ext_e2_sound", 32'(sound), 32'h1);
        car = 2'b00; tick();
        chk("ext_e3_viol", 32'(viol_cnt), 32'd4);
        chk("ext_e3_sound", 32'(sound), 32'h1);
        for (int k = 4; k <= 6; k++) begin
            tick();
            chk($sformatf("ext_e%0d_sound", k), 32'(sound), 32'h1);
        end
        tick();
        chk("ext_e7_sound", 32'(sound), 32'h0);

        // Bring the digit from 2 to 9 with single-lane passes
        for (int k = 0; k < 7; k++) lane0_pass();
        chk("dig9_out", 32'(out), 32'h6F);

        // Simultaneous passes at digit 9 wrap to 1
        car = 2'b11; hp = 8'h00; tick();
        hp = 8'hEE; tick();
        chk("sim_pass_gate", 32'(gate), 32'h3);
        chk("sim_pass_out", 32'(out), 32'h06);
        car = 2'b00; hp = 8'h00; tick();
        chk("sim_pass_close", 32'(gate), 32'h0);

        // Simultaneous timeouts add two violations in one cycle
        car = 2'b11; tick();
        for (int k = 1; k < 16; k++) tick();
        chk("sim_tmo_before", 32'(viol_cnt), 32'd4);
        tick();
        chk("sim_tmo_viol", 32'(viol_cnt), 32'd6);
        car = 2'b00; tick();

        // Narrow counter saturates rather than wrapping
        for (int k = 1; k <= 5; k++) begin
            car2 = 2'b01; tick();
            car2 = 2'b00; tick();
            chk($sformatf("sat_v%0d", k), 32'(viol_cnt2), 32'((k > 3) ? 3 : k));
            tick();
        end

        // Twelve passes on the narrow instance, digit wraps through 0
        for (int k = 1; k <= 6; k++) begin
            car2 = 2'b11; hp2 = 8'h00; tick();
            hp2 = 8'h88; tick();
            car2 = 2'b00; hp2 = 8'h00; tick();
            chk($sformatf("wrap_p%0d_out", 2 * k), 32'(out2), 32'(seg_ref[(2 * k) % 10]));
        end
        chk("wrap_final_out", 32'(out2), 32'h5B);

        // Reset mid-transaction clears everything without a clock edge
        lane0_pass();
        car = 2'b01; tick();
        hp = 8'h0E; tick();
        chk("mid_gate_open", 32'(gate), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_gate", 32'(gate), 32'h0);
        chk("mid_rst_out", 32'(out), 32'h3F);
        chk("mid_rst_viol", 32'(viol_cnt), 32'h0);
        chk("mid_rst_sound", 32'(sound), 32'h0);
        car = 2'b00; hp = 8'h00;
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_out", 32'(out), 32'h3F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hipass_toll_ctrl.md
# hipass_toll_ctrl

Multi-lane successor to the single-lane toll gate top. Each lane runs its own vehicle/tag FSM: it detects car arrival, waits a bounded time for a hi-pass tag, then opens the gate or logs a violation. Lanes share a saturating violation counter, a pass-digit counter driving the 7-segment display, and a retriggerable buzzer. It sits between the lane sensors and hi-pass readers and the booth display/buzzer.

## Interface
- LANES, 2: number of independent lanes (1..8)
- TAG_W, 4: width of each lane's hipass_out code (≥2)
- CNT_W, 8: violation counter width
- TIMEOUT, 16: cycles a lane waits for a tag after car arrival (≥2)
- SOUND_CYC, 4: buzzer pulse length in cycles (≥1)

- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- car  in  LANES  per-lane vehicle-present sensor, level
- hipass_out  in  LANES*TAG_W  lane i tag code at [i*TAG_W +: TAG_W]; 0 = no tag
- gate  out  LANES  per-lane gate-open, registered
- out  out  7  7-seg {g,f,e,d,c,b,a}, active-high, shows pass digit 0–9
- sound  out  1  buzzer, registered
- viol_cnt  out  CNT_W  total violations, saturating

## Operation
- Tag decode: code==0 means no tag. Nonzero with MSB=1 means valid, balance OK. Nonzero with MSB=0 means low balance.
- Per-lane FSM states: IDLE, WAIT_TAG, PASS, VIOL.
  - IDLE: car rising edge (car & ~car_q) → WAIT_TAG and load the timer with TIMEOUT-1.
  - WAIT_TAG, checked in priority order:
    - car low → VIOL (drive-through).
    - Valid tag → PASS.
    - Low-balance tag → VIOL.
    - Timer==0 → VIOL.
    - Otherwise decrement the timer.
  - PASS: gate=1. Car low → IDLE.
  - VIOL: gate=0. Car low → IDLE. If car is already low on entry, the FSM goes to IDLE on the next cycle.
- Events, each a 1-cycle strobe per lane:
  - pass_ev is asserted on the WAIT_TAG→PASS transition.
  - viol_ev is asserted on the WAIT_TAG→VIOL transition.
- Pass digit: adds popcount(pass_ev) modulo 10 (9+1→0; 9+2→1).
- viol_cnt: adds popcount(viol_ev). It saturates at 2^CNT_W−1 and never wraps.
- Sound: any viol_ev loads a down-counter with SOUND_CYC. sound=1 while the counter is nonzero. A new violation reloads the counter, which extends the tone.
- 7-seg encoding for digits 0–9: 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex, bit0=a).

## Timing
- Reset values: all FSMs IDLE, gate=0, sound=0, viol_cnt=0, digit=0, out=7'h3F. car_q resets to 0, so a car held high through reset release counts as an arrival on the first clock.
- Reset asserted mid-operation clears everything immediately, asynchronously. The transaction in progress is lost and not counted.
- Car rise sampled at edge N → state WAIT_TAG after edge N.
- Valid tag present at edge M during WAIT_TAG → gate=1 after edge M. The digit and out update after the same edge M.
- The tag is sampled only in WAIT_TAG. Tags in IDLE, PASS or VIOL are ignored.
- No tag arrives → VIOL is entered at edge N+TIMEOUT. sound=1 after that edge and stays high for exactly SOUND_CYC cycles.
- Car falls during PASS → gate=0 after the next edge.
- A car re-arriving requires a fresh rising edge. Car held high in VIOL or PASS never re-triggers.
- Lanes are fully independent. Simultaneous events on several lanes are all counted in the same cycle.

## Structure
- Shared package toll_pkg holds:
  - lane state encoding (IDLE=0, WAIT_TAG=1, PASS=2, VIOL=3);
  - the 10-entry 7-seg constant table;
  - the tag decode helpers (is_valid, is_low).
- Sub-module toll_lane_fsm contains one lane's FSM, timer, car_q edge detector and event strobes. It is instantiated LANES times with a generate loop.
- The top level holds the popcount adders, the digit/viol/sound counters and the 7-seg lookup.

## Test plan
- Reset: rst=0 with car=2'b11 and tags nonzero → gate=0, sound=0, viol_cnt=0, out=3F. Release rst with car=01 held → lane0 is in WAIT_TAG after the first edge.
- Lane0 pass: car rise, then hipass_out lane0=4'b1110 on the 3rd cycle → gate[0]=1 the next cycle, out=06. Car low → gate[0]=0 after one edge.
- Low balance: lane1 car rise, tag 4'b0100 → no gate, viol_cnt=1, sound high for 4 cycles.
- Timeout: lane0 car rise, no tag → VIOL at cycle 16, viol_cnt+1. Repeat the car rise inside the sound window → sound is extended, not restarted at 0.
- Simultaneous: both lanes get valid tags in the same cycle with the digit at 9 → out=06 (digit 1). Both lanes time out together → viol_cnt +2.
- Saturation/wrap: CNT_W=2, five violations → viol_cnt=3. Twelve passes → out=5B (digit 2).
